// File: rtl/buffer_ram_wr_arbiter_if.sv
// Write-side bus of the frame buffer arbiter: capture stream, clear control,
// status flags and the RAM write port.
interface buffer_ram_wr_arbiter_if #(
  parameter int unsigned AW = 17,
  parameter int unsigned DW = 16
);
  logic          cap_valid;
  logic          cap_sof;
  logic [DW-1:0] cap_data;
  logic          cap_ready;
  logic          clr_start;
  logic [DW-1:0] clr_color;
  logic          clr_busy;
  logic          clr_done;
  logic          frame_done;
  logic          drop_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_we;

  // master: requesters and RAM observer; slave: the arbiter itself
  modport master (
    output cap_valid, cap_sof, cap_data, clr_start, clr_color,
    input  cap_ready, clr_busy, clr_done, frame_done, drop_err,
           mem_addr, mem_data, mem_we
  );

  modport slave (
    input  cap_valid, cap_sof, cap_data, clr_start, clr_color,
    output cap_ready, clr_busy, clr_done, frame_done, drop_err,
           mem_addr, mem_data, mem_we
  );
endinterface

// File: rtl/buffer_ram_wr_arbiter.sv
// Write-port arbiter for the 320x240 RGB565 frame buffer: camera capture
// has priority, a frame-clear engine fills the buffer with one colour.
module buffer_ram_wr_arbiter #(
  parameter int unsigned AW   = 17,
  parameter int unsigned DW   = 16,
  parameter int unsigned NPIX = 76800
) (
  input  logic                   clk,
  input  logic                   rst,
  buffer_ram_wr_arbiter_if.slave bus
);

  localparam logic [AW-1:0] LAST = AW'(NPIX - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, CLEAR} state_t;

  state_t        state;
  logic [AW-1:0] cap_addr;
  logic [AW-1:0] clr_addr;
  logic          pending;
  logic [DW-1:0] fill;
  logic          clr_last;
  logic          accept;

  assign accept = bus.cap_valid && bus.cap_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cap_addr       <= '0;
      clr_addr       <= '0;
      pending        <= 1'b0;
      fill           <= '0;
      clr_last       <= 1'b0;
      bus.cap_ready  <= 1'b0;
      bus.clr_busy   <= 1'b0;
      bus.clr_done   <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.drop_err   <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_data   <= '0;
      bus.mem_we     <= 1'b0;
    end else begin
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.frame_done <= 1'b0;
      bus.clr_busy   <= 1'b0;
      bus.cap_ready  <= 1'b1;
      bus.clr_done   <= clr_last;
      clr_last       <= 1'b0;

      case (state)
        IDLE: begin
          if (accept && bus.cap_sof) begin
            bus.mem_we   <= 1'b1;
            bus.mem_data <= bus.cap_data;
            cap_addr     <= AW'(1);
            state        <= CAPTURE;
            if (bus.clr_start) begin
              pending <= 1'b1;
              fill    <= bus.clr_color;
            end
          end else if (pending || bus.clr_start) begin
            // non-sof pixels seen here are simply discarded
            state         <= CLEAR;
            pending       <= 1'b0;
            clr_addr      <= '0;
            bus.cap_ready <= 1'b0;
            if (bus.clr_start) fill <= bus.clr_color;
          end
        end

        CAPTURE: begin
          if (bus.clr_start) begin
            pending <= 1'b1;
            fill    <= bus.clr_color;
          end
          if (accept) begin
            bus.mem_we   <= 1'b1;
            bus.mem_data <= bus.cap_data;
            if (bus.cap_sof) begin
              cap_addr <= AW'(1);
            end else begin
              bus.mem_addr <= cap_addr;
              if (cap_addr == LAST) begin
                bus.frame_done <= 1'b1;
                cap_addr       <= '0;
                state          <= IDLE;
              end else begin
                cap_addr <= cap_addr + AW'(1);
              end
            end
          end
        end

        CLEAR: begin
          bus.mem_we   <= 1'b1;
          bus.mem_addr <= clr_addr;
          bus.mem_data <= fill;
          bus.clr_busy <= 1'b1;
          if (bus.cap_valid) bus.drop_err <= 1'b1;
          // clr_done follows one cycle behind the last write
          if (clr_addr == LAST) begin
            clr_addr <= '0;
            clr_last <= 1'b1;
            state    <= IDLE;
          end else begin
            clr_addr      <= clr_addr + AW'(1);
            bus.cap_ready <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_ram_wr_arbiter.sv
// Scoreboard bench for buffer_ram_wr_arbiter, reduced frame size for runtime.
module tb_buffer_ram_wr_arbiter;

  localparam int unsigned AW   = 17;
  localparam int unsigned DW   = 16;
  localparam int unsigned NPIX = 300;
  localparam int unsigned KRST = 200;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          fd;
    logic          busy;
  } exp_t;

  logic clk;
  logic rst;
  exp_t q[$];
  int   vec;
  int   errs;
  int   n_done;
  int   exp_done;

  buffer_ram_wr_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  buffer_ram_wr_arbiter #(.AW(AW), .DW(DW), .NPIX(NPIX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vec++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic push(input int a, input logic [DW-1:0] d, input logic fd, input logic busy);
    exp_t e;
    e.addr = AW'(a);
    e.data = d;
    e.fd   = fd;
    e.busy = busy;
    q.push_back(e);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic sof, input logic cs, input logic [DW-1:0] cc);
    bus.cap_valid = 1'b1;
    bus.cap_data  = d;
    bus.cap_sof   = sof;
    bus.clr_start = cs;
    bus.clr_color = cc;
    tick();
    bus.cap_valid = 1'b0;
    bus.cap_sof   = 1'b0;
    bus.clr_start = 1'b0;
  endtask

  task automatic pulse_clr(input logic [DW-1:0] color, input int n);
    for (int k = 0; k < n; k++) push(k, color, 1'b0, 1'b1);
    bus.clr_start = 1'b1;
    bus.clr_color = color;
    tick();
    bus.clr_start = 1'b0;
  endtask

  task automatic wait_done();
    int prev;
    int n;
    prev = n_done;
    n    = 0;
    while (n_done == prev && n < 2 * NPIX + 20) begin
      tick();
      n++;
    end
    chk("clr_done_seen", 32'(n_done > prev), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 2 * NPIX + 20) begin
      tick();
      n++;
    end
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  // Monitor: every RAM write is matched against the expected-write queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.clr_done) n_done++;
      if (bus.mem_we) begin
        vec++;
        if (q.size() == 0) begin
          errs++;
          $display("FAIL unexpected_write addr=%0d data=%h", bus.mem_addr, bus.mem_data);
        end else begin
          e = q.pop_front();
          if (bus.mem_addr !== e.addr || bus.mem_data !== e.data ||
              bus.frame_done !== e.fd || bus.clr_busy !== e.busy) begin
            errs++;
            $display("FAIL write got a=%0d d=%h fd=%b busy=%b want a=%0d d=%h fd=%b busy=%b",
                     bus.mem_addr, bus.mem_data, bus.frame_done, bus.clr_busy,
                     e.addr, e.data, e.fd, e.busy);
          end
        end
      end else begin
        vec++;
        if (bus.frame_done !== 1'b0 || bus.clr_busy !== 1'b0) begin
          errs++;
          $display("FAIL idle_flags got fd=%b busy=%b want 0 0", bus.frame_done, bus.clr_busy);
        end
      end
    end
  end

  initial begin
    vec = 0; errs = 0; n_done = 0; exp_done = 0;
    rst = 1'b1;
    bus.cap_valid = 1'b0;
    bus.cap_sof   = 1'b0;
    bus.cap_data  = '0;
    bus.clr_start = 1'b0;
    bus.clr_color = '0;
    tick();
    tick();

    // reset state
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_mem_data", 32'(bus.mem_data), 0);
    chk("rst_cap_ready", 32'(bus.cap_ready), 0);
    chk("rst_clr_busy", 32'(bus.clr_busy), 0);
    chk("rst_clr_done", 32'(bus.clr_done), 0);
    chk("rst_frame_done", 32'(bus.frame_done), 0);
    chk("rst_drop_err", 32'(bus.drop_err), 0);
    rst = 1'b0;
    tick();
    chk("idle_cap_ready", 32'(bus.cap_ready), 1);

    // short stream: sof then two pixels
    push(0, 16'h1234, 1'b0, 1'b0);
    push(1, 16'h0055, 1'b0, 1'b0);
    push(2, 16'h0066, 1'b0, 1'b0);
    send(16'h1234, 1'b1, 1'b0, 16'h0);
    send(16'h0055, 1'b0, 1'b0, 16'h0);
    send(16'h0066, 1'b0, 1'b0, 16'h0);

    // full frame, starting with a resync sof mid-capture
    for (int i = 0; i < NPIX; i++) begin
      push(i, 16'(i), 1'(i == NPIX - 1), 1'b0);
      send(16'(i), 1'(i == 0), 1'b0, 16'h0);
    end
    send(16'hDEAD, 1'b0, 1'b0, 16'h0);
    tick();
    drain();
    chk("no_drop_after_frame", 32'(bus.drop_err), 0);

    // clear from idle
    pulse_clr(16'h00EA, NPIX);
    exp_done++;
    wait_done();
    chk("ready_after_clear", 32'(bus.cap_ready), 1);
    chk("busy_after_clear", 32'(bus.clr_busy), 0);

    // clear requested mid-frame twice: frame finishes, last colour wins
    for (int i = 0; i < NPIX; i++) begin
      push(i, 16'(i) ^ 16'h5A5A, 1'(i == NPIX - 1), 1'b0);
      send(16'(i) ^ 16'h5A5A, 1'(i == 0), 1'((i == 100) || (i == 150)),
           (i == 100) ? 16'h0A0A : 16'h0B0B);
    end
    for (int k = 0; k < NPIX; k++) push(k, 16'h0B0B, 1'b0, 1'b1);
    exp_done++;
    wait_done();
    drain();

    // capture attempts during a clear are dropped
    pulse_clr(16'h1111, NPIX);
    exp_done++;
    bus.cap_valid = 1'b1;
    bus.cap_sof   = 1'b1;
    bus.cap_data  = 16'h7777;
    for (int k = 0; k < 3; k++) begin
      chk("cap_ready_in_clear", 32'(bus.cap_ready), 0);
      tick();
    end
    bus.cap_valid = 1'b0;
    bus.cap_sof   = 1'b0;
    chk("drop_err_set", 32'(bus.drop_err), 1);
    wait_done();
    chk("drop_err_sticky", 32'(bus.drop_err), 1);
    drain();

    // reset in the middle of a clear
    pulse_clr(16'h2222, KRST);
    begin
      int n;
      n = 0;
      while (!(bus.mem_we && bus.mem_addr == AW'(KRST - 1)) && n < 2 * NPIX) begin
        tick();
        n++;
      end
      chk("reached_rst_point", 32'(n < 2 * NPIX), 1);
    end
    rst = 1'b1;
    tick();
    chk("midrst_mem_we", 32'(bus.mem_we), 0);
    chk("midrst_clr_busy", 32'(bus.clr_busy), 0);
    chk("midrst_drop_err", 32'(bus.drop_err), 0);
    chk("midrst_mem_data", 32'(bus.mem_data), 0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 32'(bus.cap_ready), 1);
    push(0, 16'h4321, 1'b0, 1'b0);
    send(16'h4321, 1'b1, 1'b0, 16'h0);
    repeat (4) tick();
    drain();
    chk("post_rst_no_clear", 32'(bus.clr_busy), 0);

    chk("queue_empty", 32'(q.size()), 0);
    chk("clr_done_count", 32'(n_done), 32'(exp_done));
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/buffer_ram_wr_arbiter.md
Name: buffer_ram_wr_arbiter

Overview:
- Sequences and arbitrates the write port of the dual-port frame buffer, a 76800 x 16-bit RAM holding a 320x240 RGB565 image.
- Two requesters share the port: the camera capture stream, and a frame-clear engine that fills the whole buffer with one colour.
- Drives the buffer's addr_in, data_in and regwrite directly. The read port stays with the display side.

Parameters:
- AW, 17, address width.
- DW, 16, pixel width.
- NPIX, 76800, pixels per frame. Valid addresses are 0..NPIX-1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- cap_valid  input  1  capture pixel present this cycle.
- cap_sof  input  1  start of frame; qualified by cap_valid, marks the pixel for address 0.
- cap_data  input  DW  capture pixel value.
- cap_ready  output  1  capture pixel is accepted when cap_valid && cap_ready.
- clr_start  input  1  single-cycle request to clear the frame.
- clr_color  input  DW  fill colour, sampled in the cycle clr_start is latched.
- clr_busy  output  1  high while the clear is writing.
- clr_done  output  1  one-cycle pulse after the last clear write.
- frame_done  output  1  one-cycle pulse after a complete captured frame.
- drop_err  output  1  sticky flag: a capture pixel was lost.
- mem_addr  output  AW  to buffer addr_in.
- mem_data  output  DW  to buffer data_in.
- mem_we  output  1  to buffer regwrite.

Behaviour:
- Reset: every output is 0. State goes to IDLE. Address counters and the pending-clear latch clear. Reset mid-frame or mid-clear abandons the operation; mem_we is 0 from the first cycle after the reset edge.
- States: IDLE, CAPTURE, CLEAR.
- cap_ready = 1 in IDLE and CAPTURE, 0 in CLEAR.
- All mem_* outputs are registered. A pixel accepted in cycle N appears on mem_addr/mem_data with mem_we=1 in cycle N+1. Write latency is one cycle.
- IDLE:
  - Accepted pixel with cap_sof=1: write it to address 0, set the capture address to 1, go to CAPTURE.
  - Accepted pixel with cap_sof=0: discard it, no write, drop_err unchanged (pre-sync idle).
  - No capture start, but a clear is pending or clr_start=1: go to CLEAR, latch clr_color, set the clear address to 0.
- CAPTURE:
  - Each accepted pixel writes at the capture address, then the address increments.
  - Accepted pixel with cap_sof=1: resync. It writes to address 0, the next address is 1, no frame_done.
  - Write to address NPIX-1: the address wraps to 0, frame_done pulses in the same cycle mem_we asserts for that address, and the state returns to IDLE.
  - Any further pixels without sof are discarded (IDLE rule).
- CLEAR:
  - Writes clr_color to addresses 0..NPIX-1, one per cycle; mem_we is continuously 1 for exactly NPIX cycles.
  - clr_busy = 1 from the cycle after entry until the last write cycle, inclusive.
  - clr_done pulses the cycle after the last write. The state then returns to IDLE and the pending-clear latch clears.
  - cap_valid=1 while in CLEAR: the pixel is lost and drop_err sets. drop_err clears only on rst.
- Arbitration:
  - Capture has priority; a clear never preempts a frame in progress.
  - clr_start arriving in CAPTURE, or in the same IDLE cycle as an accepted sof, sets the pending latch. The clear starts on the first IDLE cycle with no sof accepted. clr_color is sampled when clr_start is latched.
  - Multiple clr_start pulses while pending collapse into one clear; the last colour wins.
  - clr_start during CLEAR is ignored.
- Counters are AW bits wide, compared against NPIX-1, and never exceed NPIX-1.
- mem_data holds its last value when mem_we=0; mem_addr is 0 when idle.

Test Plan:
- Reset, then sof pixel 0x1234 followed by 2 pixels -> mem_we on the next 3 cycles, addresses 0,1,2, data 0x1234 then the stream values; frame_done stays 0.
- Full frame of 76800 pixels, data = address[15:0] -> last write at 76799 with frame_done=1 in that cycle. Reading the buffer afterwards: address 76700 = 76700 mod 65536 = 11164, address 0 = 0. The state returns to IDLE.
- clr_start with clr_color=0x00EA in IDLE -> clr_busy for 76800 cycles, all addresses read back 234, clr_done pulses once at the end.
- clr_start at pixel 100 of a frame -> the frame completes uninterrupted, the clear starts the cycle after frame_done, and the final buffer is all clr_color.
- cap_valid asserted during CLEAR -> cap_ready=0, no capture write, drop_err=1 and still 1 after the clear ends; rst clears it.
- rst at clear address 5000 -> mem_we=0 from the next cycle, state IDLE, clr_busy=0. A following sof pixel writes to address 0.
